map_lookup_arbiter: RTL and testbench
=====================================

// Module: map_lookup_arbiter
// PURPOSE
//  Shares the two read ports of the 32x32 maze bitmap ROM among NREQ tile-lookup requesters
//  (player movement, ghost AI, collision logic). Each requester asks "is tile (x,y) a wall?".
//  Up to two lookups are granted per cycle in round-robin order, one on port A and one on port B.
//  The wall bit is returned to the originating requester with a one-cycle response pulse.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  COORD_W  5   tile coordinate width; map is 2**COORD_W x 2**COORD_W
// PORTS
//  clk         in   1             system clock
//  reset       in   1             asynchronous, active-high reset
//  req_valid   in   NREQ          per-requester lookup request (level)
//  req_x       in   NREQ*COORD_W  column, requester i at [i*COORD_W +: COORD_W]
//  req_y       in   NREQ*COORD_W  row, same packing
//  resp_valid  out  NREQ          one-cycle pulse: lookup for requester i complete
//  resp_wall   out  NREQ          wall bit for requester i; valid only while resp_valid[i]
//  map_addr_a  out  COORD_W       row address to map ROM port A (registered)
//  map_addr_b  out  COORD_W       row address to map ROM port B (registered)
//  map_row_a   in   2**COORD_W    row data from port A (combinational from map_addr_a)
//  map_row_b   in   2**COORD_W    row data from port B
// BEHAVIOUR
//  - Reset: resp_valid=0, resp_wall=0, map_addr_a/b=0, busy mask=0, rr pointer=0, grant valids=0.
//  - Handshake: requester holds req_valid, req_x, req_y stable until it sees resp_valid[i].
//    In the resp_valid cycle it may drop req_valid or present new coords for a back-to-back lookup.
//  - Eligible set: req_valid & ~busy.
//  - Grant edge E1: pick up to two eligible requesters, scanning upward from rr pointer with wrap.
//    First winner -> port A, second -> port B.
//    Register map_addr_a/b <= winner's y. Register winner id and x, set grant_a/grant_b valid.
//    Set busy[winner].
//  - Response edge E1+1: for each valid grant: resp_valid[id] <= 1;
//    resp_wall[id] <= map_row[(2**COORD_W-1) - x] (bit 31 = column 0, leftmost). Clear busy[id].
//    All other resp_valid bits <= 0.
//  - Latency: req_valid rises before E1 -> resp_valid high in the cycle after E1+1 (2 clocks).
//  - Busy is still set at E1+1, so a requester is never regranted on stale coords.
//    Max rate is one lookup per requester every 2 cycles.
//    Aggregate throughput is 2 lookups per cycle.
//  - rr pointer: after a grant, pointer <= (last granted id + 1) mod NREQ. No grant -> unchanged.
//  - Single eligible requester: it takes port A; port B grant invalid; map_addr_b holds its value.
//  - Same row on both ports is legal: both ports read the same address.
//  - Grant and response for different requesters overlap in the same edge (fully pipelined).
//  - Dropped req: if req_valid falls while busy, the response still pulses; requester ignores it.
//  - Reset mid-operation: in-flight grants are discarded; no response pulses after release.
//  - All coordinates are in range by construction; no bounds checking.
// STRUCTURE
//  - Shared package map_pkg: MAP_COORD_W=5, MAP_W=32, MAP_H=32, function map_bit_idx(x) = MAP_W-1-x.
//    The map ROM and renderers use the same package.
//  - One sub-module rr_pick2: combinational; inputs eligible mask and pointer.
//    Outputs win0/win1 ids and valid bits.
//  - Remaining logic lives in map_lookup_arbiter: grant regs, busy mask, response regs.
// TESTING
//  1. Req0 (x=4,y=2) alone after reset: map_addr_a=2; resp_valid[0] 2 clocks later, resp_wall=0.
//     Repeat with x=3: resp_wall=1.
//  2. All four req at once (y=6, x=0/16/30/31): {0,1} granted at E1, {2,3} at E1+1.
//     Responses resp_wall = 1,0,1,1 on consecutive cycles.
//  3. All four held back-to-back, new coords each response: grants alternate {0,1},{2,3}.
//     Each requester gets exactly one response per 2 cycles over 100 cycles.
//  4. Req1 and req3 only, pointer=2: req3 -> port A, req1 -> port B; pointer becomes 2.
//  5. Reset asserted one cycle after req0 granted: resp_valid stays 0 through and after reset.
//     map_addr_a=0.
//  6. Req2 changes to (x=8,y=0x0C) in its resp cycle with req held: second response 2 clocks later.
//     resp_wall=1.

Source files
------------

// File: rtl/map_pkg.sv
// Maze-map geometry shared by the map ROM, the renderers and the lookup arbiter.
// Bit 31 of a ROM row is column 0, the leftmost tile.
package map_pkg;

  localparam int MAP_COORD_W = 5;
  localparam int MAP_W       = 32;
  localparam int MAP_H       = 32;

  function automatic logic [MAP_COORD_W-1:0] map_bit_idx(input logic [MAP_COORD_W-1:0] x);
    return MAP_COORD_W'(MAP_W - 1) - x;
  endfunction

endpackage

// File: rtl/map_lookup_arbiter_rr_pick2.sv
// Combinational round-robin picker: selects up to two set bits of an eligible
// mask, scanning upward from a start pointer with wrap-around.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win0,
  output logic            win0_vld,
  output logic [IDW-1:0]  win1,
  output logic            win1_vld
);

  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NREQ);

  logic [NREQ-1:0] rot;

  // Requester id at scan offset `off` from the pointer, modulo NREQ.
  function automatic logic [IDW-1:0] abs_id(input logic [IDW-1:0] base, input int off);
    logic [IDW:0] s;
    s = {1'b0, base} + (IDW+1)'(off);
    if (s >= NREQ_L) s = s - NREQ_L;
    return s[IDW-1:0];
  endfunction

  // Rotate so that bit 0 of rot is the requester the pointer names.
  assign rot = NREQ'({eligible, eligible} >> ptr);

  always_comb begin
    win0     = '0;
    win0_vld = 1'b0;
    win1     = '0;
    win1_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i]) begin
        if (!win0_vld) begin
          win0     = abs_id(ptr, i);
          win0_vld = 1'b1;
        end else if (!win1_vld) begin
          win1     = abs_id(ptr, i);
          win1_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/map_lookup_arbiter.sv
// Shares the two maze-ROM read ports among NREQ tile-lookup requesters: two
// round-robin grants per cycle, wall bit returned as a one-cycle response pulse.
module map_lookup_arbiter
  import map_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int COORD_W = MAP_COORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*COORD_W-1:0] req_x,
  input  logic [NREQ*COORD_W-1:0] req_y,
  output logic [NREQ-1:0]         resp_valid,
  output logic [NREQ-1:0]         resp_wall,
  output logic [COORD_W-1:0]      map_addr_a,
  output logic [COORD_W-1:0]      map_addr_b,
  input  logic [2**COORD_W-1:0]   map_row_a,
  input  logic [2**COORD_W-1:0]   map_row_b
);

  localparam int           IDW    = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NREQ);

  logic [COORD_W-1:0] x_arr [NREQ];
  logic [COORD_W-1:0] y_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*COORD_W +: COORD_W];
    assign y_arr[g] = req_y[g*COORD_W +: COORD_W];
  end

  logic [NREQ-1:0]    busy;
  logic [IDW-1:0]     ptr;

  logic [NREQ-1:0]    elig_p0;
  logic [IDW-1:0]     win0_p0, win1_p0;
  logic               vld0_p0, vld1_p0;

  logic               vld_a_p1, vld_b_p1;
  logic [IDW-1:0]     id_a_p1, id_b_p1;
  logic [COORD_W-1:0] x_a_p1, x_b_p1;
  logic               wall_a_p1, wall_b_p1;

  logic [NREQ-1:0]    busy_set, busy_clr;
  logic [NREQ-1:0]    resp_valid_nxt, resp_wall_nxt;
  logic [IDW-1:0]     ptr_nxt;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW:0] s;
    s = {1'b0, id} + (IDW+1)'(1);
    if (s >= NREQ_L) s = '0;
    return s[IDW-1:0];
  endfunction

  // ---- stage p0: eligibility and round-robin selection ----
  // A busy requester is excluded until its response edge, so it is never
  // regranted on the coordinates it is still holding for the current lookup.
  assign elig_p0 = req_valid & ~busy;

  rr_pick2 #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .eligible (elig_p0),
    .ptr      (ptr),
    .win0     (win0_p0),
    .win0_vld (vld0_p0),
    .win1     (win1_p0),
    .win1_vld (vld1_p0)
  );

  always_comb begin
    ptr_nxt = ptr;
    if (vld1_p0)      ptr_nxt = next_id(win1_p0);
    else if (vld0_p0) ptr_nxt = next_id(win0_p0);
  end

  // ---- stage p1: ROM row arrives for the registered grants ----
  assign wall_a_p1 = map_row_a[map_bit_idx(x_a_p1)];
  assign wall_b_p1 = map_row_b[map_bit_idx(x_b_p1)];

  always_comb begin
    busy_set       = '0;
    busy_clr       = '0;
    resp_valid_nxt = '0;
    resp_wall_nxt  = resp_wall;
    for (int i = 0; i < NREQ; i++) begin
      if (vld0_p0 && win0_p0 == IDW'(i)) busy_set[i] = 1'b1;
      if (vld1_p0 && win1_p0 == IDW'(i)) busy_set[i] = 1'b1;
      if (vld_a_p1 && id_a_p1 == IDW'(i)) begin
        busy_clr[i]       = 1'b1;
        resp_valid_nxt[i] = 1'b1;
        resp_wall_nxt[i]  = wall_a_p1;
      end
      if (vld_b_p1 && id_b_p1 == IDW'(i)) begin
        busy_clr[i]       = 1'b1;
        resp_valid_nxt[i] = 1'b1;
        resp_wall_nxt[i]  = wall_b_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      ptr        <= '0;
      vld_a_p1   <= 1'b0;
      vld_b_p1   <= 1'b0;
      map_addr_a <= '0;
      map_addr_b <= '0;
      resp_valid <= '0;
      resp_wall  <= '0;
    end else begin
      busy       <= (busy & ~busy_clr) | busy_set;
      ptr        <= ptr_nxt;
      vld_a_p1   <= vld0_p0;
      vld_b_p1   <= vld1_p0;
      if (vld0_p0) map_addr_a <= y_arr[win0_p0];
      if (vld1_p0) map_addr_b <= y_arr[win1_p0];
      resp_valid <= resp_valid_nxt;
      resp_wall  <= resp_wall_nxt;
    end
  end

  // Grant payload only matters while its valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (vld0_p0) begin
      id_a_p1 <= win0_p0;
      x_a_p1  <= x_arr[win0_p0];
    end
    if (vld1_p0) begin
      id_b_p1 <= win1_p0;
      x_b_p1  <= x_arr[win1_p0];
    end
  end

endmodule

// File: tb/tb_map_lookup_arbiter.sv
// Self-checking bench for map_lookup_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference of the arbitration rules.
`timescale 1ns/1ps
module tb_map_lookup_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CW-1:0]   req_x, req_y;
  logic [NREQ-1:0]      resp_valid, resp_wall;
  logic [CW-1:0]        map_addr_a, map_addr_b;
  logic [31:0]          map_row_a, map_row_b;

  logic [CW-1:0]        xs [NREQ];
  logic [CW-1:0]        ys [NREQ];
  logic [31:0]          maze [32];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: who is waiting, round-robin start, lookups in flight.
  logic [NREQ-1:0]      mbusy;
  int                   mptr;
  int                   fl_n;
  int                   fl_id [2];
  bit                   fl_wall [2];
  logic [NREQ-1:0]      exp_rv, exp_rw;
  logic [CW-1:0]        exp_a, exp_b;

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*CW +: CW] = xs[i];
      req_y[i*CW +: CW] = ys[i];
    end
  end

  assign map_row_a = maze[map_addr_a];
  assign map_row_b = maze[map_addr_b];

  map_lookup_arbiter #(.NREQ(NREQ), .COORD_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_wall  (resp_wall),
    .map_addr_a (map_addr_a),
    .map_addr_b (map_addr_b),
    .map_row_a  (map_row_a),
    .map_row_b  (map_row_b)
  );

  function automatic bit wall_at(input int x, input int y);
    logic [31:0] row;
    row = maze[y];
    return row[31 - x];
  endfunction

  task automatic model_reset();
    mbusy = '0; mptr = 0; fl_n = 0;
    exp_rv = '0; exp_rw = '0; exp_a = '0; exp_b = '0;
  endtask

  // One clock edge of the reference: grant up to two waiting requesters in
  // round-robin order, and deliver the lookups granted on the previous edge.
  task automatic model_edge();
    int ng;
    int nid [2];
    bit nw [2];
    int id;
    ng = 0;
    for (int k = 0; k < NREQ; k++) begin
      id = (mptr + k) % NREQ;
      if (req_valid[id] && !mbusy[id] && ng < 2) begin
        nid[ng] = id;
        nw[ng]  = wall_at(int'(xs[id]), int'(ys[id]));
        if (ng == 0) exp_a = ys[id];
        else         exp_b = ys[id];
        ng++;
      end
    end
    if (ng > 0) mptr = (nid[ng-1] + 1) % NREQ;
    exp_rv = '0;
    for (int j = 0; j < fl_n; j++) begin
      exp_rv[fl_id[j]] = 1'b1;
      exp_rw[fl_id[j]] = fl_wall[j];
      mbusy[fl_id[j]]  = 1'b0;
    end
    fl_n = ng;
    for (int j = 0; j < ng; j++) begin
      fl_id[j]   = nid[j];
      fl_wall[j] = nw[j];
      mbusy[nid[j]] = 1'b1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 4'b0) $display("FAIL rst_resp_valid: got %b want 0000", resp_valid); else n_pass++;
    n_checks++; if (resp_wall !== 4'b0) $display("FAIL rst_resp_wall: got %b want 0000", resp_wall); else n_pass++;
    n_checks++; if (map_addr_a !== 5'd0) $display("FAIL rst_addr_a: got %0d want 0", map_addr_a); else n_pass++;
    n_checks++; if (map_addr_b !== 5'd0) $display("FAIL rst_addr_b: got %0d want 0", map_addr_b); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    xs[0] = 5'd4; ys[0] = 5'd2; req_valid = 4'b0001;
    step();
    n_checks++; if (map_addr_a !== 5'd2) $display("FAIL single_addr_a: got %0d want 2", map_addr_a); else n_pass++;
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL single_early: got %b want 0000", resp_valid); else n_pass++;
    step();
    n_checks++; if (resp_valid !== 4'b0001) $display("FAIL single_rv1: got %b want 0001", resp_valid); else n_pass++;
    n_checks++; if (resp_wall[0] !== 1'b0) $display("FAIL single_wall_x4: got %b want 0", resp_wall[0]); else n_pass++;
    xs[0] = 5'd3;
    step();
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL single_gap: got %b want 0000", resp_valid); else n_pass++;
    step();
    n_checks++; if (resp_valid !== 4'b0001) $display("FAIL single_rv2: got %b want 0001", resp_valid); else n_pass++;
    n_checks++; if (resp_wall[0] !== 1'b1) $display("FAIL single_wall_x3: got %b want 1", resp_wall[0]); else n_pass++;
    req_valid = '0;
    step();
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL single_idle: got %b want 0000", resp_valid); else n_pass++;
  endtask

  task automatic test_all_four();
    apply_reset();
    xs[0] = 5'd0; xs[1] = 5'd16; xs[2] = 5'd30; xs[3] = 5'd31;
    for (int i = 0; i < NREQ; i++) ys[i] = 5'd6;
    req_valid = 4'b1111;
    step();
    n_checks++; if (map_addr_a !== 5'd6 || map_addr_b !== 5'd6) $display("FAIL four_addr_e1: got %0d/%0d want 6/6", map_addr_a, map_addr_b); else n_pass++;
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL four_rv_e1: got %b want 0000", resp_valid); else n_pass++;
    step();
    n_checks++; if (resp_valid !== 4'b0011) $display("FAIL four_rv_01: got %b want 0011", resp_valid); else n_pass++;
    n_checks++; if (resp_wall[1:0] !== 2'b01) $display("FAIL four_wall_01: got %b want 01", resp_wall[1:0]); else n_pass++;
    req_valid[1:0] = 2'b00;
    step();
    n_checks++; if (resp_valid !== 4'b1100) $display("FAIL four_rv_23: got %b want 1100", resp_valid); else n_pass++;
    n_checks++; if (resp_wall[3:2] !== 2'b11) $display("FAIL four_wall_23: got %b want 11", resp_wall[3:2]); else n_pass++;
    req_valid = '0;
    step();
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL four_idle: got %b want 0000", resp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cnt [NREQ];
    logic [NREQ-1:0] want;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0; xs[i] = 5'($urandom); ys[i] = 5'($urandom);
    end
    req_valid = 4'b1111;
    for (int n = 1; n <= 100; n++) begin
      step();
      want = (n == 1) ? 4'b0000 : ((n % 2 == 0) ? 4'b0011 : 4'b1100);
      n_checks++; if (resp_valid !== want) $display("FAIL b2b_rv cyc %0d: got %b want %b", n, resp_valid, want); else n_pass++;
      n_checks++; if ((resp_wall & exp_rv) !== (exp_rw & exp_rv)) $display("FAIL b2b_wall cyc %0d: got %b want %b", n, resp_wall & exp_rv, exp_rw & exp_rv); else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i]) begin
          cnt[i]++;
          xs[i] = 5'($urandom); ys[i] = 5'($urandom);
        end
      end
    end
    n_checks++; if (cnt[0] != 50 || cnt[1] != 50) $display("FAIL b2b_cnt01: got %0d/%0d want 50/50", cnt[0], cnt[1]); else n_pass++;
    n_checks++; if (cnt[2] != 49 || cnt[3] != 49) $display("FAIL b2b_cnt23: got %0d/%0d want 49/49", cnt[2], cnt[3]); else n_pass++;
    req_valid = '0;
    repeat (2) step();
  endtask

  task automatic test_pointer_wrap();
    apply_reset();
    ys[0] = 5'd1; ys[1] = 5'd2; req_valid = 4'b0011;
    step();
    req_valid = '0;
    step();
    ys[1] = 5'd20; ys[3] = 5'd21; xs[1] = 5'd7; xs[3] = 5'd9;
    req_valid = 4'b1010;
    step();
    n_checks++; if (map_addr_a !== 5'd21) $display("FAIL ptr_port_a: got %0d want 21", map_addr_a); else n_pass++;
    n_checks++; if (map_addr_b !== 5'd20) $display("FAIL ptr_port_b: got %0d want 20", map_addr_b); else n_pass++;
    step();
    n_checks++; if (resp_valid !== 4'b1010) $display("FAIL ptr_rv: got %b want 1010", resp_valid); else n_pass++;
    ys[2] = 5'd22;
    req_valid = 4'b1110;
    step();
    n_checks++; if (map_addr_a !== 5'd22 || map_addr_b !== 5'd21) $display("FAIL ptr_after: got %0d/%0d want 22/21", map_addr_a, map_addr_b); else n_pass++;
    req_valid = '0;
    step();
    n_checks++; if (resp_valid !== 4'b1100) $display("FAIL ptr_rv2: got %b want 1100", resp_valid); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    xs[0] = 5'd7; ys[0] = 5'd9; req_valid = 4'b0001;
    step();
    n_checks++; if (map_addr_a !== 5'd9) $display("FAIL midrst_grant: got %0d want 9", map_addr_a); else n_pass++;
    reset = 1'b1;
    req_valid = '0;
    model_reset();
    #1;
    n_checks++; if (map_addr_a !== 5'd0) $display("FAIL midrst_addr_a: got %0d want 0", map_addr_a); else n_pass++;
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL midrst_rv_now: got %b want 0000", resp_valid); else n_pass++;
    for (int n = 0; n < 2; n++) begin
      step();
      n_checks++; if (resp_valid !== 4'b0000) $display("FAIL midrst_rv_in cyc %0d: got %b want 0000", n, resp_valid); else n_pass++;
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      n_checks++; if (resp_valid !== 4'b0000) $display("FAIL midrst_rv_after cyc %0d: got %b want 0000", n, resp_valid); else n_pass++;
    end
  endtask

  task automatic test_new_coords();
    apply_reset();
    xs[2] = 5'd5; ys[2] = 5'd3; req_valid = 4'b0100;
    step();
    step();
    n_checks++; if (resp_valid !== 4'b0100) $display("FAIL newc_rv1: got %b want 0100", resp_valid); else n_pass++;
    xs[2] = 5'd8; ys[2] = 5'h0C;
    step();
    n_checks++; if (resp_valid !== 4'b0000) $display("FAIL newc_gap: got %b want 0000", resp_valid); else n_pass++;
    n_checks++; if (map_addr_a !== 5'h0C) $display("FAIL newc_addr_a: got %0d want 12", map_addr_a); else n_pass++;
    n_checks++; if (map_addr_b !== 5'd0) $display("FAIL newc_addr_b_hold: got %0d want 0", map_addr_b); else n_pass++;
    step();
    n_checks++; if (resp_valid !== 4'b0100) $display("FAIL newc_rv2: got %b want 0100", resp_valid); else n_pass++;
    n_checks++; if (resp_wall[2] !== 1'b1) $display("FAIL newc_wall: got %b want 1", resp_wall[2]); else n_pass++;
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((req_valid[i] && resp_valid[i]) || (!req_valid[i] && !mbusy[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          xs[i] = 5'($urandom);
          ys[i] = 5'($urandom);
        end else if (req_valid[i] && mbusy[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      step();
      n_checks++; if (resp_valid !== exp_rv) $display("FAIL rand_rv cyc %0d: got %b want %b", n, resp_valid, exp_rv); else n_pass++;
      n_checks++; if ((resp_wall & exp_rv) !== (exp_rw & exp_rv)) $display("FAIL rand_wall cyc %0d: got %b want %b", n, resp_wall & exp_rv, exp_rw & exp_rv); else n_pass++;
      n_checks++; if (map_addr_a !== exp_a) $display("FAIL rand_addr_a cyc %0d: got %0d want %0d", n, map_addr_a, exp_a); else n_pass++;
      n_checks++; if (map_addr_b !== exp_b) $display("FAIL rand_addr_b cyc %0d: got %0d want %0d", n, map_addr_b, exp_b); else n_pass++;
    end
    req_valid = '0;
    repeat (2) step();
  endtask

  initial begin
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end
    for (int r = 0; r < 32; r++) maze[r] = $urandom();
    // Tiles the directed scenarios depend on (bit 31 is column 0).
    maze[2][27]  = 1'b0;
    maze[2][28]  = 1'b1;
    maze[6][31]  = 1'b1;
    maze[6][15]  = 1'b0;
    maze[6][1]   = 1'b1;
    maze[6][0]   = 1'b1;
    maze[12][23] = 1'b1;

    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_pointer_wrap();
    test_reset_mid();
    test_new_coords();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
